// File: rtl/control_unit_pipe_if.sv
// control_unit_pipe_if: ID-stage inputs and ID/EX control outputs of control_unit_pipe.
// illegal_op exists only when CU_ILLEGAL_TRAP_EN is defined.
interface control_unit_pipe_if;
  logic        id_valid;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic        eq_ne;
  logic        ex_stall;
  logic        id_stall;
  logic        flush_if;
  logic [1:0]  pc_source;
  logic [17:0] ex_ctrl;
  logic        ex_valid;
  logic        mult_busy;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif
  modport master (
    output id_valid, op_code, funct, eq_ne, ex_stall,
`ifdef CU_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    input  id_stall, flush_if, pc_source, ex_ctrl, ex_valid, mult_busy
  );
  modport slave (
    input  id_valid, op_code, funct, eq_ne, ex_stall,
`ifdef CU_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    output id_stall, flush_if, pc_source, ex_ctrl, ex_valid, mult_busy
  );
endinterface

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: pipelined MIPS control decoder with mult interlock, ID/EX hold and IF flush.
// Define CU_ILLEGAL_TRAP_EN to add the registered illegal_op trap output.
module control_unit_pipe #(
  parameter int MULT_LATENCY      = 4,
  parameter int BRANCH_DELAY_SLOT = 0
) (
  input logic clk,
  input logic reset,
  control_unit_pipe_if.slave cu
);
  logic [17:0] base, word;
  logic        legal, nop, is_mul, is_mf, is_beq, is_bne, is_j;
  logic        hazard, taken, accept;
  logic [5:0]  cnt;
  always_comb begin
    base   = '0;
    legal  = 1'b1;
    nop    = 1'b0;
    is_mul = 1'b0;
    is_mf  = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    case (cu.op_code)
      6'b000000:
        case (cu.funct)
          6'b100000: base = 18'h32001;
          6'b100010: base = 18'h32801;
          6'b100100: base = 18'h30001;
          6'b100101: base = 18'h30801;
          6'b101010: base = 18'h33801;
          6'b011000: begin base = 18'h00030; is_mul = 1'b1; end
          6'b011001: begin base = 18'h00020; is_mul = 1'b1; end
          6'b010000: begin base = 18'h30040; is_mf = 1'b1; end
          6'b010010: begin base = 18'h30080; is_mf = 1'b1; end
          6'b000000: nop = 1'b1;
          default:   legal = 1'b0;
        endcase
      6'b001000: base = 18'h2A100;
      6'b001100: base = 18'h28000;
      6'b001101: base = 18'h28800;
      6'b100011: base = 18'h2A101;
      6'b101011: base = 18'h0A500;
      6'b000100: begin base = 18'h02800; is_beq = 1'b1; end
      6'b000101: begin base = 18'h02800; is_bne = 1'b1; end
      6'b000010: begin base = 18'h00004; is_j = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end
  assign hazard       = cu.id_valid & (cnt != '0) & (is_mul | is_mf);
  assign cu.id_stall  = cu.ex_stall | hazard;
  assign taken        = cu.id_valid & ~cu.id_stall & (is_j | (is_beq & cu.eq_ne) | (is_bne & ~cu.eq_ne));
  assign cu.pc_source = ~taken ? 2'b00 : is_j ? 2'b10 : 2'b01;
  assign cu.flush_if  = taken & (BRANCH_DELAY_SLOT == 0);
  assign accept       = cu.id_valid & ~cu.id_stall & legal & ~nop;
  // Taken conditional branches additionally carry output_branch and pc_source=01 into EX.
  assign word         = base | ((taken & ~is_j) ? 18'h0000A : 18'h00000);
  assign cu.mult_busy = cnt != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      cu.ex_ctrl  <= '0;
      cu.ex_valid <= 1'b0;
    end else if (!cu.ex_stall) begin
      cu.ex_ctrl  <= accept ? word : '0;
      cu.ex_valid <= accept;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (accept && is_mul) cnt <= 6'(MULT_LATENCY);
    else if (cnt != '0) cnt <= cnt - 6'd1;
  end
`ifdef CU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) cu.illegal_op <= 1'b0;
    else cu.illegal_op <= cu.id_valid & ~cu.id_stall & ~legal;
  end
`endif
endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: directed and randomized checks of control_unit_pipe against an instruction-table model.
module tb_control_unit_pipe;
  localparam int LAT = 4;
  typedef enum {K_ALU, K_MUL, K_MF, K_BEQ, K_BNE, K_J, K_NOP, K_ILL} kind_t;
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [17:0] word;
    kind_t       kind;
  } ins_t;
  localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_LW = 6'h23;
  localparam logic [5:0] FN_ADD = 6'h20, FN_MULT = 6'h18, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
  localparam logic [17:0] W_ADD = 18'h32001, W_LW = 18'h2A101, W_MFHI = 18'h30040, W_MFLO = 18'h30080;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_unit_pipe_if bus ();
  control_unit_pipe_if bus_ds ();
  control_unit_pipe #(.MULT_LATENCY(LAT), .BRANCH_DELAY_SLOT(0)) dut (.clk(clk), .reset(reset), .cu(bus.slave));
  control_unit_pipe #(.MULT_LATENCY(LAT), .BRANCH_DELAY_SLOT(1)) dut_ds (.clk(clk), .reset(reset), .cu(bus_ds.slave));
  assign bus_ds.id_valid = bus.id_valid;
  assign bus_ds.op_code  = bus.op_code;
  assign bus_ds.funct    = bus.funct;
  assign bus_ds.eq_ne    = bus.eq_ne;
  assign bus_ds.ex_stall = bus.ex_stall;

  int checks = 0;
  int failures = 0;
  ins_t tbl[$];
  logic [17:0] m_ctrl = '0;
  logic m_valid = 1'b0;
  logic m_ill = 1'b0;
  int m_left = 0;

  function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, logic [17:0] w, kind_t k);
    ins_t r;
    r.op = op; r.fn = fn; r.word = w; r.kind = k;
    return r;
  endfunction

  function automatic ins_t classify(logic [5:0] op, logic [5:0] fn);
    foreach (tbl[i])
      if (tbl[i].op == op && (op != OP_R || tbl[i].fn == fn)) return tbl[i];
    return mk(op, fn, 18'h0, K_ILL);
  endfunction

  function automatic void exp_comb(output logic stall, output logic tk, output logic [1:0] pcs);
    ins_t i = classify(bus.op_code, bus.funct);
    stall = bus.ex_stall | (bus.id_valid & (m_left > 0) & (i.kind == K_MUL || i.kind == K_MF));
    tk = bus.id_valid & !stall & (i.kind == K_J || (i.kind == K_BEQ && bus.eq_ne) || (i.kind == K_BNE && !bus.eq_ne));
    pcs = !tk ? 2'd0 : (i.kind == K_J) ? 2'd2 : 2'd1;
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic st);
    bus.id_valid = v; bus.op_code = op; bus.funct = fn; bus.eq_ne = eq; bus.ex_stall = st;
    #1;
  endtask

  task automatic tick();
    ins_t i = classify(bus.op_code, bus.funct);
    logic stall, tk, acc;
    logic [1:0] pcs;
    logic [17:0] w;
    exp_comb(stall, tk, pcs);
    acc = bus.id_valid & !stall & !(i.kind == K_NOP || i.kind == K_ILL);
    w = i.word;
    if (tk) begin
      w[3] = (i.kind != K_J);
      w[2:1] = pcs;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_ctrl = '0; m_valid = 1'b0; m_left = 0; m_ill = 1'b0;
    end else begin
      if (!bus.ex_stall) begin
        m_ctrl = acc ? w : '0;
        m_valid = acc;
      end
      m_left = (acc && i.kind == K_MUL) ? LAT : (m_left > 0 ? m_left - 1 : 0);
      m_ill = bus.id_valid & !stall & (i.kind == K_ILL);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, OP_R, FN_ADD, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.ex_ctrl !== 18'h0 || bus.ex_valid !== 1'b0 || bus.mult_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d ex_ctrl=%h ex_valid=%b mult_busy=%b want 0/0/0", c, bus.ex_ctrl, bus.ex_valid, bus.mult_busy);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.ex_ctrl !== W_ADD || bus.ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_release ex_ctrl=%h ex_valid=%b want %h/1", bus.ex_ctrl, bus.ex_valid, W_ADD);
    end
  endtask

  task automatic test_mult_interlock();
    int stall_n = 0, busy_n = 0, edges = 0;
    drive(1, OP_R, FN_MULT, 0, 0);
    tick();
    drive(1, OP_R, FN_MFHI, 0, 0);
    for (int c = 0; c < 20; c++) begin
      if (bus.id_stall) stall_n++;
      if (bus.mult_busy) busy_n++;
      tick();
      if (bus.ex_valid === 1'b1 && bus.ex_ctrl === W_MFHI) begin
        edges = c + 1;
        break;
      end
    end
    checks++;
    if (stall_n != LAT) begin failures++; $display("FAIL mult_stall_cycles got=%0d want=%0d", stall_n, LAT); end
    checks++;
    if (busy_n != LAT) begin failures++; $display("FAIL mult_busy_cycles got=%0d want=%0d", busy_n, LAT); end
    checks++;
    if (edges != LAT + 1) begin failures++; $display("FAIL mfhi_issue_edge got=%0d want=%0d", edges, LAT + 1); end
  endtask

  task automatic test_branch();
    drive(1, OP_BEQ, 6'h00, 1, 0);
    checks++;
    if (bus.pc_source !== 2'b01 || bus.flush_if !== 1'b1 || bus_ds.flush_if !== 1'b0 || bus_ds.pc_source !== 2'b01) begin
      failures++;
      $display("FAIL beq_taken pcs=%b flush=%b ds_pcs=%b ds_flush=%b want 01/1/01/0", bus.pc_source, bus.flush_if, bus_ds.pc_source, bus_ds.flush_if);
    end
    tick();
    checks++;
    if (bus.ex_ctrl !== 18'h0280A) begin failures++; $display("FAIL beq_taken_ctrl got=%h want=0280a", bus.ex_ctrl); end
    drive(1, OP_BEQ, 6'h00, 0, 0);
    checks++;
    if (bus.pc_source !== 2'b00 || bus.flush_if !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken pcs=%b flush=%b want 00/0", bus.pc_source, bus.flush_if);
    end
    tick();
    checks++;
    if (bus.ex_ctrl !== 18'h02800) begin failures++; $display("FAIL beq_nt_ctrl got=%h want=02800", bus.ex_ctrl); end
    drive(1, OP_BNE, 6'h00, 0, 0);
    checks++;
    if (bus.pc_source !== 2'b01 || bus.flush_if !== 1'b1) begin
      failures++;
      $display("FAIL bne_taken pcs=%b flush=%b want 01/1", bus.pc_source, bus.flush_if);
    end
    tick();
    drive(1, OP_J, 6'h00, 0, 0);
    checks++;
    if (bus.pc_source !== 2'b10 || bus.flush_if !== 1'b1 || bus_ds.flush_if !== 1'b0) begin
      failures++;
      $display("FAIL jump pcs=%b flush=%b ds_flush=%b want 10/1/0", bus.pc_source, bus.flush_if, bus_ds.flush_if);
    end
    tick();
    checks++;
    if (bus.ex_ctrl !== 18'h00004) begin failures++; $display("FAIL jump_ctrl got=%h want=00004", bus.ex_ctrl); end
    drive(1, OP_BEQ, 6'h00, 1, 1);
    checks++;
    if (bus.pc_source !== 2'b00 || bus.flush_if !== 1'b0 || bus.id_stall !== 1'b1) begin
      failures++;
      $display("FAIL stalled_branch pcs=%b flush=%b stall=%b want 00/0/1", bus.pc_source, bus.flush_if, bus.id_stall);
    end
    tick();
    drive(0, 6'h00, 6'h00, 0, 0);
    tick();
  endtask

  task automatic test_ex_stall();
    drive(1, OP_R, FN_MULT, 0, 0);
    tick();
    drive(1, OP_LW, 6'h00, 0, 0);
    tick();
    checks++;
    if (bus.ex_ctrl !== W_LW) begin failures++; $display("FAIL lw_ctrl got=%h want=%h", bus.ex_ctrl, W_LW); end
    drive(1, OP_R, FN_ADD, 0, 1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.id_stall !== 1'b1) begin failures++; $display("FAIL ex_stall_id_stall cyc=%0d got=%b want=1", c, bus.id_stall); end
      tick();
      checks++;
      if (bus.ex_ctrl !== W_LW || bus.ex_valid !== 1'b1) begin
        failures++;
        $display("FAIL ex_stall_hold cyc=%0d ex_ctrl=%h ex_valid=%b want %h/1", c, bus.ex_ctrl, bus.ex_valid, W_LW);
      end
    end
    checks++;
    if (bus.mult_busy !== 1'b0) begin failures++; $display("FAIL stall_decrement mult_busy=%b want=0", bus.mult_busy); end
    drive(1, OP_R, FN_ADD, 0, 0);
    tick();
  endtask

  task automatic test_illegal();
    drive(1, 6'h3F, 6'h00, 0, 0);
    checks++;
    if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL illegal_no_stall got=%b want=0", bus.id_stall); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 18'h0) begin
      failures++;
      $display("FAIL illegal_bubble ex_ctrl=%h ex_valid=%b want 0/0", bus.ex_ctrl, bus.ex_valid);
    end
`ifdef CU_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_pulse got=%b want=1", bus.illegal_op); end
`endif
    drive(1, OP_R, FN_ADD, 0, 0);
    tick();
`ifdef CU_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b want=0", bus.illegal_op); end
`endif
  endtask

  task automatic test_reset_mid_mult();
    drive(1, OP_R, FN_MULT, 0, 0);
    tick();
    drive(1, OP_R, FN_MFLO, 0, 0);
    tick();
    checks++;
    if (bus.id_stall !== 1'b1) begin failures++; $display("FAIL mflo_stalled got=%b want=1", bus.id_stall); end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.mult_busy !== 1'b0 || bus.ex_ctrl !== 18'h0) begin
      failures++;
      $display("FAIL reset_mid_mult busy=%b ex_ctrl=%h want 0/0", bus.mult_busy, bus.ex_ctrl);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.id_stall !== 1'b0) begin failures++; $display("FAIL mflo_released got=%b want=0", bus.id_stall); end
    tick();
    checks++;
    if (bus.ex_ctrl !== W_MFLO || bus.ex_valid !== 1'b1 || bus.mult_busy !== 1'b0) begin
      failures++;
      $display("FAIL mflo_issue ex_ctrl=%h ex_valid=%b busy=%b want %h/1/0", bus.ex_ctrl, bus.ex_valid, bus.mult_busy, W_MFLO);
    end
  endtask

  task automatic test_random();
    logic stall, tk;
    logic [1:0] pcs;
    ins_t pick;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 6)
        pick = ($urandom_range(0, 1) == 0) ? mk(6'h3E, 6'h00, 18'h0, K_ILL) : mk(OP_R, 6'h3F, 18'h0, K_ILL);
      else if ($urandom_range(0, 99) < 30)
        pick = mk(OP_R, ($urandom_range(0, 1) == 0) ? FN_MULT : FN_MFLO, 18'h0, K_MUL);
      else
        pick = tbl[$urandom_range(0, tbl.size() - 1)];
      drive($urandom_range(0, 99) < 85, pick.op, pick.fn, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 20);
      exp_comb(stall, tk, pcs);
      checks++;
      if (bus.id_stall !== stall || bus.pc_source !== pcs || bus.flush_if !== tk || bus_ds.flush_if !== 1'b0) begin
        failures++;
        $display("FAIL rand_comb cyc=%0d stall=%b pcs=%b flush=%b ds_flush=%b want %b/%b/%b/0", c, bus.id_stall, bus.pc_source, bus.flush_if, bus_ds.flush_if, stall, pcs, tk);
      end
      tick();
      checks++;
      if (bus.ex_ctrl !== m_ctrl || bus.ex_valid !== m_valid || bus.mult_busy !== (m_left > 0)) begin
        failures++;
        $display("FAIL rand_reg cyc=%0d ex_ctrl=%h ex_valid=%b busy=%b want %h/%b/%b", c, bus.ex_ctrl, bus.ex_valid, bus.mult_busy, m_ctrl, m_valid, m_left > 0);
      end
`ifdef CU_ILLEGAL_TRAP_EN
      checks++;
      if (bus.illegal_op !== m_ill) begin failures++; $display("FAIL rand_illegal cyc=%0d got=%b want=%b", c, bus.illegal_op, m_ill); end
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    tbl.push_back(mk(OP_R, FN_ADD, W_ADD, K_ALU));
    tbl.push_back(mk(OP_R, 6'h22, 18'h32801, K_ALU));
    tbl.push_back(mk(OP_R, 6'h24, 18'h30001, K_ALU));
    tbl.push_back(mk(OP_R, 6'h25, 18'h30801, K_ALU));
    tbl.push_back(mk(OP_R, 6'h2A, 18'h33801, K_ALU));
    tbl.push_back(mk(OP_R, FN_MULT, 18'h00030, K_MUL));
    tbl.push_back(mk(OP_R, 6'h19, 18'h00020, K_MUL));
    tbl.push_back(mk(OP_R, FN_MFHI, W_MFHI, K_MF));
    tbl.push_back(mk(OP_R, FN_MFLO, W_MFLO, K_MF));
    tbl.push_back(mk(OP_R, 6'h00, 18'h0, K_NOP));
    tbl.push_back(mk(6'h08, 6'h00, 18'h2A100, K_ALU));
    tbl.push_back(mk(6'h0C, 6'h00, 18'h28000, K_ALU));
    tbl.push_back(mk(6'h0D, 6'h00, 18'h28800, K_ALU));
    tbl.push_back(mk(OP_LW, 6'h00, W_LW, K_ALU));
    tbl.push_back(mk(6'h2B, 6'h00, 18'h0A500, K_ALU));
    tbl.push_back(mk(OP_BEQ, 6'h00, 18'h02800, K_BEQ));
    tbl.push_back(mk(OP_BNE, 6'h00, 18'h02800, K_BNE));
    tbl.push_back(mk(OP_J, 6'h00, 18'h00004, K_J));
    test_reset();
    test_mult_interlock();
    test_branch();
    test_ex_stall();
    test_illegal();
    test_reset_mid_mult();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
